mmcm_lock_supervisor: RTL and testbench

Free-running supervisor for the PPU clock MMCM, clocked by the HDMI input clock. Drives the MMCM reset, watches the asynchronous `locked` status, and holds the PPU-domain reset request until lock has been stable for a settle window. Recovers automatically from lock timeout and lock loss, and keeps saturating event counters for debug. It runs on `clk_hdmi` because `clk_ppu8` stops whenever the MMCM is unlocked.

---
 rtl/mmcm_lock_supervisor.sv | 126 ++++++++++++
 tb/tb_mmcm_lock_supervisor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mmcm_lock_supervisor.sv
// Supervisor for the PPU clock MMCM: pulses the MMCM reset, waits for a stable
// lock, releases the PPU reset request and recovers from timeout or lock loss.
module mmcm_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT     = 65536,
  parameter int unsigned SETTLE_CYCLES    = 1024,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned CNT_W            = 8
) (
  input  logic             clk_hdmi,
  input  logic             reset,
  input  logic             locked,
  output logic             mmcm_reset,
  output logic             rst_ppu,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int unsigned MAX_RT = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_N  = (MAX_RT > SETTLE_CYCLES) ? MAX_RT : SETTLE_CYCLES;
  // One spare bit keeps the all-ones reset preload above every terminal count.
  localparam int unsigned CW     = $clog2(MAX_N) + 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_MMCM,
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   timeout_hit, loss_hit;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;

  always_ff @(posedge clk_hdmi) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lk = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + 1'b1;
    timeout_hit = 1'b0;
    loss_hit    = 1'b0;
    case (state)
      RESET_MMCM: begin
        if (cnt == RST_LAST) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nx    = RESET_MMCM;
          cnt_nx      = '0;
          timeout_hit = 1'b1;
        end
      end
      SETTLE: begin
        if (!lk) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        cnt_nx = '0;
        if (!lk) begin
          state_nx = RESET_MMCM;
          loss_hit = 1'b1;
        end
      end
      default: begin
        state_nx = RESET_MMCM;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_hdmi) begin
    if (reset) begin
      state         <= RESET_MMCM;
      // Preload so the first edge after reset wraps cnt to 0 and counts as
      // the entry edge: the pulse then spans cycles 0..RST_PULSE_CYCLES-1.
      cnt           <= '1;
      mmcm_reset    <= 1'b1;
      rst_ppu       <= 1'b1;
      ready         <= 1'b0;
      lock_lost     <= 1'b0;
      loss_count    <= '0;
      timeout_count <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      mmcm_reset <= (state_nx == RESET_MMCM);
      rst_ppu    <= (state_nx != RUN);
      ready      <= (state_nx == RUN);
      lock_lost  <= loss_hit;
      if (loss_hit && (loss_count != '1)) begin
        loss_count <= loss_count + 1'b1;
      end
      if (timeout_hit && (timeout_count != '1)) begin
        timeout_count <= timeout_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// Directed bench for mmcm_lock_supervisor: clean start, timeout saturation,
// settle glitch, loss in RUN, simultaneous timeout/lock and mid-run reset.
module tb_mmcm_lock_supervisor;

  localparam int RPC = 4;
  localparam int LT  = 32;
  localparam int SC  = 16;
  localparam int SS  = 2;
  localparam int CW  = 4;

  logic          clk_hdmi = 1'b0;
  logic          reset;
  logic          locked;
  logic          mmcm_reset;
  logic          rst_ppu;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] loss_count;
  logic [CW-1:0] timeout_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk_hdmi = ~clk_hdmi;

  mmcm_lock_supervisor #(
    .RST_PULSE_CYCLES(RPC),
    .LOCK_TIMEOUT    (LT),
    .SETTLE_CYCLES   (SC),
    .SYNC_STAGES     (SS),
    .CNT_W           (CW)
  ) dut (
    .clk_hdmi     (clk_hdmi),
    .reset        (reset),
    .locked       (locked),
    .mmcm_reset   (mmcm_reset),
    .rst_ppu      (rst_ppu),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .loss_count   (loss_count),
    .timeout_count(timeout_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int mr, input int rp,
                            input int ll, input int lc, input int tc);
    check({tag, ".mmcm_reset"},    int'(mmcm_reset),    mr);
    check({tag, ".rst_ppu"},       int'(rst_ppu),       rp);
    check({tag, ".ready"},         int'(ready),         1 - rp);
    check({tag, ".lock_lost"},     int'(lock_lost),     ll);
    check({tag, ".loss_count"},    int'(loss_count),    lc);
    check({tag, ".timeout_count"}, int'(timeout_count), tc);
  endtask

  task automatic step();
    @(posedge clk_hdmi);
    #1;
    cyc++;
  endtask

  // Two reset edges with locked low, then release so the next edge is cycle 0.
  task automatic do_reset();
    reset  = 1'b1;
    locked = 1'b0;
    step();
    step();
    reset = 1'b0;
    cyc   = -1;
  endtask

  // locked rises after edge 10 -> lk at 12 -> SETTLE at 13 -> RUN at 29.
  task automatic clean_start(input string tag);
    while (cyc < 35) begin
      step();
      check_outs(tag, int'(cyc <= 3), int'(cyc < 29), 0, 0, 0);
      if (cyc == 10) locked = 1'b1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    locked = 1'b0;
    repeat (3) step();
    check_outs("reset", 1, 1, 0, 0, 0);
    reset = 1'b0;
    cyc   = -1;
    clean_start("clean");

    // Timeout: WAIT at 4, timeout every 36 cycles, count saturates at 15.
    do_reset();
    while (cyc < 620) begin
      step();
      check_outs("timeout", int'((cyc % 36) < 4), 1, 0, 0,
                 ((cyc / 36) > 15) ? 15 : (cyc / 36));
    end

    // lk rises on the edge where cnt reaches 31: lock wins over timeout.
    do_reset();
    while (cyc < 60) begin
      step();
      check_outs("simul", int'(cyc <= 3), int'(cyc < 52), 0, 0, 0);
      if (cyc == 33) locked = 1'b1;
    end

    // Glitch in the 8th SETTLE cycle: WAIT at 23, SETTLE at 24, RUN at 40.
    do_reset();
    while (cyc < 50) begin
      step();
      check_outs("glitch", int'(cyc <= 3), int'(cyc < 40), 0, 0, 0);
      if (cyc == 10) locked = 1'b1;
      if (cyc == 20) locked = 1'b0;
      if (cyc == 21) locked = 1'b1;
    end

    // Loss at 50: reset 53..56, WAIT 57, relock at 60 -> SETTLE 63 -> RUN 79.
    locked = 1'b0;
    while (cyc < 95) begin
      step();
      check_outs("loss", int'(cyc >= 53 && cyc <= 56), int'(cyc >= 53 && cyc < 79),
                 int'(cyc == 53), (cyc >= 53) ? 1 : 0, 0);
      if (cyc == 60) locked = 1'b1;
    end

    // Second loss plus one timeout so both counters are nonzero.
    locked = 1'b0;
    while (cyc < 170) begin
      step();
      check_outs("loss2",
                 int'((cyc >= 98 && cyc <= 101) || (cyc >= 134 && cyc <= 137)),
                 int'(cyc >= 98 && cyc < 164), int'(cyc == 98),
                 (cyc >= 98) ? 2 : 1, (cyc >= 134) ? 1 : 0);
      if (cyc == 145) locked = 1'b1;
    end

    // Mid-run reset for two edges, then the startup sequence repeats.
    reset  = 1'b1;
    locked = 1'b0;
    step();
    check_outs("midrst", 1, 1, 0, 0, 0);
    step();
    check_outs("midrst", 1, 1, 0, 0, 0);
    reset = 1'b0;
    cyc   = -1;
    clean_start("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
